// File: rtl/mux_scan_pkg.sv
// Shared types and select codes for the mux_3_1 channel scanner.
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef logic [1:0] ch_t;

    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;

    // Returns {sel0, sel1}; sel1 is never asserted together with sel0.
    function automatic logic [1:0] sel_code(input ch_t ch);
        case (ch)
            2'd1:    sel_code = SEL_CH1;
            2'd2:    sel_code = SEL_CH2;
            default: sel_code = SEL_CH0;
        endcase
    endfunction

endpackage

// File: rtl/mux_3_1.sv
// Combinational 3:1 mux driven by the scan sequencer: {sel0,sel1} 00->i0, 01->i1, 1x->i2.
module mux_3_1 (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic sel0,
    input  logic sel1,
    output logic y
);

    always_comb begin
        y = i0;
        if (sel0)
            y = i2;
        else if (sel1)
            y = i1;
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks mux_3_1 through channels 0..2 with a programmable dwell and publishes
// each completed sweep as a 3-bit snapshot over a valid/ready handshake.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL  = 4,
    parameter int NUM_CH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       continuous,
    input  logic       y_in,
    output logic       sel0,
    output logic       sel1,
    output logic       busy,
    output logic [2:0] snap,
    output logic       snap_valid,
    input  logic       snap_ready,
    output logic       overrun
);

    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam ch_t              LAST_CH  = ch_t'(NUM_CH - 1);

    state_t           state;
    ch_t              ch;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       shadow;

    // Selects come straight from the registered channel index; ch is 0 in IDLE.
    assign {sel0, sel1} = sel_code(ch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch         <= '0;
            cnt        <= '0;
            shadow     <= '0;
            busy       <= 1'b0;
            snap       <= '0;
            snap_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (snap_valid && snap_ready)
                snap_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                        ch    <= '0;
                        cnt   <= '0;
                    end
                end

                SCAN: begin
                    if (stop) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        ch     <= '0;
                        cnt    <= '0;
                        shadow <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (ch != LAST_CH) begin
                            shadow[ch[0]] <= y_in;
                            ch            <= ch + 2'd1;
                        end else begin
                            // Completion wins over a same-edge acceptance, so valid stays set.
                            ch         <= '0;
                            snap       <= {y_in, shadow};
                            snap_valid <= 1'b1;
                            if (snap_valid && !snap_ready)
                                overrun <= 1'b1;
                            if (!continuous) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench: two sequencers (DWELL=4 and DWELL=1) each loading a mux_3_1.
`timescale 1ns/1ps
module tb_mux_scan_sequencer;

    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       start, stop, continuous, snap_ready;
    logic [2:0] pat;
    logic       y, sel0, sel1, busy, snap_valid, overrun;
    logic [2:0] snap;

    logic       start1, stop1, cont1, ready1;
    logic [2:0] pat1;
    logic       y1, sel0_1, sel1_1, busy1, valid1, overrun1;
    logic [2:0] snap1;

    int checks = 0;
    int failures = 0;
    logic [2:0] last_snap;

    mux_3_1 u_mux (.i0(pat[0]), .i1(pat[1]), .i2(pat[2]), .sel0(sel0), .sel1(sel1), .y(y));

    mux_scan_sequencer #(.DWELL(D), .NUM_CH(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
        .y_in(y), .sel0(sel0), .sel1(sel1), .busy(busy), .snap(snap),
        .snap_valid(snap_valid), .snap_ready(snap_ready), .overrun(overrun)
    );

    mux_3_1 u_mux1 (.i0(pat1[0]), .i1(pat1[1]), .i2(pat1[2]), .sel0(sel0_1), .sel1(sel1_1), .y(y1));

    mux_scan_sequencer #(.DWELL(1), .NUM_CH(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .continuous(cont1),
        .y_in(y1), .sel0(sel0_1), .sel1(sel1_1), .busy(busy1), .snap(snap1),
        .snap_valid(valid1), .snap_ready(ready1), .overrun(overrun1)
    );

    // Expected {sel0,sel1} k cycles after the start edge: channel = (k mod sweep) / dwell.
    function automatic logic [1:0] exp_sel(input int k, input int d);
        int ch;
        ch = (k % (3 * d)) / d;
        return {(ch == 2), (ch == 1)};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        start = 0; stop = 0; continuous = 0; snap_ready = 0;
        start1 = 0; stop1 = 0; cont1 = 0; ready1 = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        pat = 3'b101;
        #2 rst_n = 0;
        #1;
        checks++;
        if ({sel0, sel1} !== 2'b00 || busy !== 1'b0 || snap !== 3'b000 || snap_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: sel=%b busy=%b snap=%b valid=%b ovr=%b, required 00 0 000 0 0",
                     {sel0, sel1}, busy, snap, snap_valid, overrun);
        end
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({sel0, sel1} !== 2'b00 || busy !== 1'b0 || snap_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle c%0d: sel=%b busy=%b valid=%b, required 00 0 0",
                         c, {sel0, sel1}, busy, snap_valid);
            end
        end
    endtask

    task automatic test_single_sweep();
        logic [2:0] p;
        continuous = 0; snap_ready = 0;
        for (int n = 0; n < 4; n++) begin
            p = (n == 0) ? 3'b101 : 3'($urandom_range(0, 7));
            pat = p;
            start = 1;
            @(negedge clk);
            start = 0;
            for (int k = 0; k < 3 * D; k++) begin
                checks++;
                if ({sel0, sel1} !== exp_sel(k, D) || busy !== 1'b1 || snap_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL sweep_sel n%0d k%0d: sel=%b busy=%b valid=%b, required %b 1 0",
                             n, k, {sel0, sel1}, busy, snap_valid, exp_sel(k, D));
                end
                @(negedge clk);
            end
            checks++;
            if (snap !== p || snap_valid !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
                failures++;
                $display("FAIL sweep_done n%0d: snap=%b valid=%b busy=%b ovr=%b, required %b 1 0 0",
                         n, snap, snap_valid, busy, overrun, p);
            end
            snap_ready = 1;
            @(negedge clk);
            snap_ready = 0;
            checks++;
            if (snap_valid !== 1'b0 || snap !== p) begin
                failures++;
                $display("FAIL sweep_accept n%0d: valid=%b snap=%b, required 0 %b", n, snap_valid, snap, p);
            end
        end
    endtask

    task automatic test_continuous_overrun();
        apply_reset();
        pat = 3'b101; continuous = 1; snap_ready = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 6 * D; k++) begin
            checks++;
            if ({sel0, sel1} !== exp_sel(k, D) || busy !== 1'b1) begin
                failures++;
                $display("FAIL cont_sel k%0d: sel=%b busy=%b, required %b 1", k, {sel0, sel1}, busy, exp_sel(k, D));
            end
            if (k == 3 * D) begin
                checks++;
                if (snap !== 3'b101 || snap_valid !== 1'b1 || overrun !== 1'b0) begin
                    failures++;
                    $display("FAIL cont_first: snap=%b valid=%b ovr=%b, required 101 1 0", snap, snap_valid, overrun);
                end
            end
            if (k == 3 * D + 2) pat = 3'b010;
            if (k == 6 * D - 1) continuous = 0;
            @(negedge clk);
        end
        checks++;
        if (snap !== 3'b010 || snap_valid !== 1'b1 || overrun !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cont_overrun: snap=%b valid=%b ovr=%b busy=%b, required 010 1 1 0",
                     snap, snap_valid, overrun, busy);
        end
        snap_ready = 1;
        @(negedge clk);
        snap_ready = 0;
        checks++;
        if (snap_valid !== 1'b0 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: valid=%b ovr=%b, required 0 1", snap_valid, overrun);
        end
    endtask

    task automatic test_abort();
        logic [2:0] p;
        apply_reset();
        pat = 3'($urandom_range(0, 7));
        start = 1;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) stop = 1;
            @(negedge clk);
        end
        stop = 0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({sel0, sel1} !== 2'b00 || busy !== 1'b0 || snap_valid !== 1'b0) begin
                failures++;
                $display("FAIL abort_idle c%0d: sel=%b busy=%b valid=%b, required 00 0 0",
                         c, {sel0, sel1}, busy, snap_valid);
            end
            @(negedge clk);
        end
        p = 3'($urandom_range(0, 7));
        pat = p;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (3 * D) @(negedge clk);
        checks++;
        if (snap !== p || snap_valid !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_resweep: snap=%b valid=%b busy=%b, required %b 1 0", snap, snap_valid, busy, p);
        end
        snap_ready = 1;
        @(negedge clk);
        snap_ready = 0;
        last_snap = p;
    endtask

    task automatic test_corner_stop();
        start = 1; stop = 1;
        @(negedge clk);
        start = 0; stop = 0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (busy !== 1'b0 || {sel0, sel1} !== 2'b00) begin
                failures++;
                $display("FAIL start_stop_idle c%0d: busy=%b sel=%b, required 0 00", c, busy, {sel0, sel1});
            end
            @(negedge clk);
        end
        pat = ~last_snap;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 3 * D; k++) begin
            if (k == 3 * D - 1) stop = 1;
            @(negedge clk);
        end
        stop = 0;
        checks++;
        if (snap_valid !== 1'b0 || busy !== 1'b0 || snap !== last_snap) begin
            failures++;
            $display("FAIL stop_at_completion: valid=%b busy=%b snap=%b, required 0 0 %b",
                     snap_valid, busy, snap, last_snap);
        end
    endtask

    task automatic test_dwell1_back_to_back();
        logic [2:0] pa, pb, pc;
        apply_reset();
        pa = 3'($urandom_range(0, 7));
        pb = ~pa;
        pc = 3'($urandom_range(0, 7));
        pat1 = pa;
        start1 = 1;
        @(negedge clk);
        start1 = 0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({sel0_1, sel1_1} !== exp_sel(k, 1) || busy1 !== 1'b1) begin
                failures++;
                $display("FAIL d1_sel k%0d: sel=%b busy=%b, required %b 1", k, {sel0_1, sel1_1}, busy1, exp_sel(k, 1));
            end
            @(negedge clk);
        end
        checks++;
        if (snap1 !== pa || valid1 !== 1'b1 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL d1_first: snap=%b valid=%b busy=%b, required %b 1 0", snap1, valid1, busy1, pa);
        end
        pat1 = pb;
        start1 = 1;
        @(negedge clk);
        start1 = 0;
        repeat (2) @(negedge clk);
        ready1 = 1;
        @(negedge clk);
        checks++;
        if (snap1 !== pb || valid1 !== 1'b1 || overrun1 !== 1'b0) begin
            failures++;
            $display("FAIL d1_accept_and_load: snap=%b valid=%b ovr=%b, required %b 1 0", snap1, valid1, overrun1, pb);
        end
        @(negedge clk);
        ready1 = 0;
        checks++;
        if (valid1 !== 1'b0) begin
            failures++;
            $display("FAIL d1_drain: valid=%b, required 0", valid1);
        end
        for (int n = 0; n < 2; n++) begin
            pat1 = (n == 0) ? pc : ~pc;
            start1 = 1;
            @(negedge clk);
            start1 = 0;
            repeat (3) @(negedge clk);
        end
        checks++;
        if (snap1 !== ~pc || valid1 !== 1'b1 || overrun1 !== 1'b1) begin
            failures++;
            $display("FAIL d1_overrun: snap=%b valid=%b ovr=%b, required %b 1 1", snap1, valid1, overrun1, ~pc);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] p;
        apply_reset();
        p = 3'($urandom_range(1, 7));
        pat = p; continuous = 1; snap_ready = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (8 * D + 1) @(negedge clk);
        checks++;
        if ({sel0, sel1} !== 2'b10 || busy !== 1'b1 || snap !== p || snap_valid !== 1'b1 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre: sel=%b busy=%b snap=%b valid=%b ovr=%b, required 10 1 %b 1 1",
                     {sel0, sel1}, busy, snap, snap_valid, overrun, p);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({sel0, sel1} !== 2'b00 || busy !== 1'b0 || snap !== 3'b000 || snap_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL arst_immediate: sel=%b busy=%b snap=%b valid=%b ovr=%b, required 00 0 000 0 0",
                     {sel0, sel1}, busy, snap, snap_valid, overrun);
        end
        @(negedge clk);
        rst_n = 1;
        continuous = 0;
        repeat (3 * D + 2) @(negedge clk);
        checks++;
        if (snap_valid !== 1'b0 || busy !== 1'b0 || snap !== 3'b000) begin
            failures++;
            $display("FAIL arst_no_partial: valid=%b busy=%b snap=%b, required 0 0 000", snap_valid, busy, snap);
        end
    endtask

    initial begin
        start = 0; stop = 0; continuous = 0; snap_ready = 0; pat = 3'b000;
        start1 = 0; stop1 = 0; cont1 = 0; ready1 = 0; pat1 = 3'b000;
        last_snap = 3'b000;
        test_reset();
        test_single_sweep();
        test_continuous_overrun();
        test_abort();
        test_corner_stop();
        test_dwell1_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
